// File: rtl/mult8u_product_accum.sv
// mult8u_product_accum: sums groups of LEN unsigned 16-bit products into an ACC_W-bit result with overflow flag
// Ports:
//   clk, rst_n (async active-low)     clock and reset
//   clear                             sync flush of current group and held result
//   in_valid/in_ready/in_product      product beat handshake
//   out_valid/out_ready/out_sum/out_ovf  single-entry result register handshake
//   beat_cnt                          beats accepted in current group
// Define ACC_SAT_EN to clamp the sum to 2^ACC_W-1 on overflow instead of wrapping.
module mult8u_product_accum #(
  parameter int ACC_W = 20,
  parameter int LEN = 16,
  localparam int CW = LEN > 1 ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CW-1:0]    beat_cnt
);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  logic [0:0] state;
  logic [ACC_W-1:0] acc, base, sum;
  logic [ACC_W:0] nxt;
  logic sticky, first, last, ovf, accept;
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  // The first beat of a group ignores the old accumulator and sticky bit, so no separate restart cycle is needed.
  always_comb begin
    accept = in_valid && in_ready;
    first = beat_cnt == '0;
    last = beat_cnt == LAST;
    base = first ? '0 : acc;
    nxt = {1'b0, base} + (ACC_W + 1)'(in_product);
    ovf = (!first && sticky) || nxt[ACC_W];
`ifdef ACC_SAT_EN
    sum = ovf ? '1 : nxt[ACC_W-1:0];
`else
    sum = nxt[ACC_W-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc <= '0;
      sticky <= 1'b0;
      beat_cnt <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      state <= ACCUM;
      acc <= '0;
      sticky <= 1'b0;
      beat_cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      sticky <= ovf;
      beat_cnt <= last ? '0 : beat_cnt + CW'(1);
      if (last) begin
        out_sum <= sum;
        out_ovf <= ovf;
        state <= HOLD;
      end
    end else if (state == HOLD && out_ready) begin
      state <= ACCUM;
    end
  end
endmodule

// File: tb/tb_mult8u_product_accum.sv
// tb_mult8u_product_accum: directed checks of the product accumulator across four parameter sets
module tb_mult8u_product_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in_product = '0;
  logic r0, v0, o0, r1, v1, o1, r2, v2, o2, r3, v3, o3;
  logic [19:0] s0, s1, s3;
  logic [17:0] s2;
  logic [3:0] b0, b2;
  logic [1:0] b1;
  logic [0:0] b3;
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  mult8u_product_accum #(.ACC_W(20), .LEN(16)) u0 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(r0), .in_product(in_product), .out_valid(v0), .out_ready(out_ready), .out_sum(s0), .out_ovf(o0), .beat_cnt(b0));
  mult8u_product_accum #(.ACC_W(20), .LEN(4)) u1 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(r1), .in_product(in_product), .out_valid(v1), .out_ready(out_ready), .out_sum(s1), .out_ovf(o1), .beat_cnt(b1));
  mult8u_product_accum #(.ACC_W(18), .LEN(16)) u2 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(r2), .in_product(in_product), .out_valid(v2), .out_ready(out_ready), .out_sum(s2), .out_ovf(o2), .beat_cnt(b2));
  mult8u_product_accum #(.ACC_W(20), .LEN(1)) u3 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(r3), .in_product(in_product), .out_valid(v3), .out_ready(out_ready), .out_sum(s3), .out_ovf(o3), .beat_cnt(b3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (r0 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", r0); else pass++;
    total++; if (v0 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", v0); else pass++;
    total++; if (s0 !== 20'h0) $display("FAIL reset_out_sum got %h want 0", s0); else pass++;
    total++; if (o0 !== 1'b0) $display("FAIL reset_out_ovf got %b want 0", o0); else pass++;
    total++; if (b0 !== 4'd0) $display("FAIL reset_beat_cnt got %0d want 0", b0); else pass++;
  endtask
  task automatic test_full_group();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_product = 16'hFE01;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 7) begin
        total++; if (b0 !== 4'd8) $display("FAIL grp_beat_cnt got %0d want 8", b0); else pass++;
        total++; if (v0 !== 1'b0) $display("FAIL grp_early_valid got %b want 0", v0); else pass++;
      end
    end
    in_valid = 1'b0;
    total++; if (v0 !== 1'b1) $display("FAIL grp_out_valid got %b want 1", v0); else pass++;
    total++; if (s0 !== 20'hFE010) $display("FAIL grp_out_sum got %h want fe010", s0); else pass++;
    total++; if (o0 !== 1'b0) $display("FAIL grp_out_ovf got %b want 0", o0); else pass++;
    total++; if (r0 !== 1'b0) $display("FAIL grp_in_ready_hold got %b want 0", r0); else pass++;
    tick();
    total++; if (v0 !== 1'b0) $display("FAIL grp_valid_drop got %b want 0", v0); else pass++;
    total++; if (r0 !== 1'b1) $display("FAIL grp_in_ready_back got %b want 1", r0); else pass++;
  endtask
  task automatic test_hold_backpressure();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_product = 16'(i);
      tick();
    end
    total++; if (v1 !== 1'b1) $display("FAIL hold_valid got %b want 1", v1); else pass++;
    total++; if (s1 !== 20'd10) $display("FAIL hold_sum got %0d want 10", s1); else pass++;
    in_product = 16'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (v1 !== 1'b1 || r1 !== 1'b0 || s1 !== 20'd10)
        $display("FAIL hold_stable cycle %0d got v=%b r=%b s=%0d want v=1 r=0 s=10", i, v1, r1, s1); else pass++;
      total++; if (b1 !== 2'd0) $display("FAIL hold_not_consumed got %0d want 0", b1); else pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (v1 !== 1'b0 || r1 !== 1'b1) $display("FAIL hold_release got v=%b r=%b want v=0 r=1", v1, r1); else pass++;
    in_valid = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      in_product = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    total++; if (v1 !== 1'b1 || s1 !== 20'd26) $display("FAIL hold_next_group got v=%b s=%0d want v=1 s=26", v1, s1); else pass++;
  endtask
  task automatic test_overflow();
    logic [17:0] exp_sum;
`ifdef ACC_SAT_EN
    exp_sum = 18'h3FFFF;
`else
    exp_sum = 18'h3FFF0;
`endif
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_product = 16'hFFFF;
    for (int i = 0; i < 16; i++) tick();
    in_valid = 1'b0;
    total++; if (v2 !== 1'b1) $display("FAIL ovf_valid got %b want 1", v2); else pass++;
    total++; if (s2 !== exp_sum) $display("FAIL ovf_sum got %h want %h", s2, exp_sum); else pass++;
    total++; if (o2 !== 1'b1) $display("FAIL ovf_flag got %b want 1", o2); else pass++;
  endtask
  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_product = 16'h0100;
    for (int i = 0; i < 7; i++) tick();
    total++; if (b0 !== 4'd7) $display("FAIL clr_pre_cnt got %0d want 7", b0); else pass++;
    clear = 1'b1;
    in_product = 16'h1234;
    tick();
    clear = 1'b0;
    total++; if (b0 !== 4'd0 || v0 !== 1'b0) $display("FAIL clr_cnt got cnt=%0d v=%b want cnt=0 v=0", b0, v0); else pass++;
    in_product = 16'h0001;
    for (int i = 0; i < 16; i++) tick();
    in_valid = 1'b0;
    total++; if (v0 !== 1'b1 || s0 !== 20'd16 || o0 !== 1'b0)
      $display("FAIL clr_next_group got v=%b s=%0d o=%b want v=1 s=16 o=0", v0, s0, o0); else pass++;
  endtask
  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    in_product = 16'h0100;
    for (int i = 0; i < 9; i++) tick();
    total++; if (b0 !== 4'd9) $display("FAIL arst_pre_cnt got %0d want 9", b0); else pass++;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (b0 !== 4'd0 || r0 !== 1'b1 || v0 !== 1'b0)
      $display("FAIL arst_mid got cnt=%0d r=%b v=%b want 0 1 0", b0, r0, v0); else pass++;
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    in_product = 16'hFE01;
    for (int i = 0; i < 16; i++) tick();
    in_valid = 1'b0;
    total++; if (v0 !== 1'b1 || s0 !== 20'hFE010) $display("FAIL arst_hold_pre got v=%b s=%h want 1 fe010", v0, s0); else pass++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (v0 !== 1'b0 || s0 !== 20'h0 || o0 !== 1'b0 || r0 !== 1'b1)
      $display("FAIL arst_hold got v=%b s=%h o=%b r=%b want 0 0 0 1", v0, s0, o0, r0); else pass++;
    #2 rst_n = 1'b1;
    tick();
    total++; if (v0 !== 1'b0 || r0 !== 1'b1) $display("FAIL arst_release got v=%b r=%b want 0 1", v0, r0); else pass++;
  endtask
  task automatic test_len1();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_product = 16'd5;
    tick();
    total++; if (v3 !== 1'b1 || s3 !== 20'd5 || r3 !== 1'b0)
      $display("FAIL len1_first got v=%b s=%0d r=%b want 1 5 0", v3, s3, r3); else pass++;
    in_product = 16'd7;
    tick();
    total++; if (v3 !== 1'b0 || r3 !== 1'b1 || s3 !== 20'd5)
      $display("FAIL len1_gap got v=%b r=%b s=%0d want 0 1 5", v3, r3, s3); else pass++;
    tick();
    in_valid = 1'b0;
    total++; if (v3 !== 1'b1 || s3 !== 20'd7) $display("FAIL len1_second got v=%b s=%0d want 1 7", v3, s3); else pass++;
    tick();
    total++; if (v3 !== 1'b0) $display("FAIL len1_drop got v=%b want 0", v3); else pass++;
  endtask
  initial begin
    test_reset();
    test_full_group();
    test_hold_backpressure();
    test_overflow();
    test_clear();
    test_async_reset();
    test_len1();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
